// File: rtl/game_history_ctrl_if.sv
// Bundle between the undo-history sequencer and its host:
// request lines, RAM strobes/addresses and occupancy status.
interface game_history_ctrl_if #(
  parameter int AW = 4
);
  logic          push;
  logic          pop;
  logic          clear;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic          state_load;
  logic [AW:0]   depth;
  logic          empty;
  logic          full;
`ifdef GAME_HISTORY_REDO_EN
  logic          redo;
  logic          redo_avail;
`endif

  modport master (
`ifdef GAME_HISTORY_REDO_EN
    output redo,
    input  redo_avail,
`endif
    output push, pop, clear,
    input  busy, mem_we, mem_waddr,
    input  mem_re, mem_raddr, state_load,
    input  depth, empty, full
  );

  modport slave (
`ifdef GAME_HISTORY_REDO_EN
    input  redo,
    output redo_avail,
`endif
    input  push, pop, clear,
    output busy, mem_we, mem_waddr,
    output mem_re, mem_raddr, state_load,
    output depth, empty, full
  );
endinterface

// File: rtl/game_history_ctrl.sv
// Undo-history sequencer: writes pre-move state to a circular RAM, reads it back on pop.
// Optional redo support is enabled with the GAME_HISTORY_REDO_EN macro.
module game_history_ctrl #(
  parameter int AW = 4
) (
  input logic               clk,
  input logic               reset,
  game_history_ctrl_if.slave hif
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LOAD
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW:0]   depth_q, depth_d;
  logic          re_q, re_d;
  logic          we;
  logic          load;
  logic          idle;
  logic          redo_req;
  logic          do_redo;
`ifdef GAME_HISTORY_REDO_EN
  logic [AW:0]   rcnt_q, rcnt_d;
`endif

  assign idle = (state_q == IDLE);

`ifdef GAME_HISTORY_REDO_EN
  assign redo_req = hif.redo;
  assign do_redo  = idle && hif.redo && !hif.clear
                    && !hif.pop && (rcnt_q != '0);
`else
  assign redo_req = 1'b0;
  assign do_redo  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    raddr_d = raddr_q;
    depth_d = depth_q;
    re_d    = 1'b0;
    we      = 1'b0;
    load    = 1'b0;
`ifdef GAME_HISTORY_REDO_EN
    rcnt_d  = rcnt_q;
`endif
    if (hif.clear) begin
      // clear wins in every state and kills any pending load
      state_d = IDLE;
      wptr_d  = '0;
      depth_d = '0;
`ifdef GAME_HISTORY_REDO_EN
      rcnt_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hif.pop) begin
            if (depth_q != '0) begin
              raddr_d = wptr_q - 1'b1;
              wptr_d  = wptr_q - 1'b1;
              depth_d = depth_q - 1'b1;
              re_d    = 1'b1;
              state_d = READ;
`ifdef GAME_HISTORY_REDO_EN
              rcnt_d  = rcnt_q + 1'b1;
`endif
            end
          end else if (do_redo) begin
            raddr_d = wptr_q;
            wptr_d  = wptr_q + 1'b1;
            depth_d = depth_q + 1'b1;
            re_d    = 1'b1;
            state_d = READ;
`ifdef GAME_HISTORY_REDO_EN
            rcnt_d  = rcnt_q - 1'b1;
`endif
          end else if (hif.push && !redo_req) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (depth_q != DEPTH_V) depth_d = depth_q + 1'b1;
`ifdef GAME_HISTORY_REDO_EN
            rcnt_d = '0;
`endif
          end
        end
        READ:    state_d = LOAD;
        LOAD: begin
          load    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      raddr_q <= '0;
      depth_q <= '0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      raddr_q <= raddr_d;
      depth_q <= depth_d;
      re_q    <= re_d;
    end
  end

`ifdef GAME_HISTORY_REDO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end

  assign hif.redo_avail = (rcnt_q != '0) && idle;
`endif

  assign hif.busy       = !idle;
  assign hif.mem_we     = we;
  assign hif.mem_waddr  = wptr_q;
  assign hif.mem_re     = re_q;
  assign hif.mem_raddr  = raddr_q;
  assign hif.state_load = load;
  assign hif.depth      = depth_q;
  assign hif.empty      = (depth_q == '0);
  assign hif.full       = (depth_q == DEPTH_V);
endmodule
